// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronises buttons/switches, sequences PAUSE/RUN/ADJUST
// and owns the MM:SS BCD time registers and per-digit blank enables.
module stopwatch_ctrl #(
    parameter int MIN_MAX     = 59,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK_REF,
    input  logic       RST_N,
    input  logic       TICK_1HZ,
    input  logic       TICK_2HZ,
    input  logic       BLINK,
    input  logic       BTN_PAUSE,
    input  logic       BTN_RESET,
    input  logic       SW_ADJ,
    input  logic       SW_SEL,
    output logic [3:0] MIN_T,
    output logic [3:0] MIN_O,
    output logic [3:0] SEC_T,
    output logic [3:0] SEC_O,
    output logic [3:0] DIG_BLANK,
    output logic       RUNNING
);

    typedef enum logic [1:0] {PAUSE, RUN, ADJUST} state_t;

    localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);

    state_t state, state_next;
    logic [SYNC_STAGES-1:0] pause_sync, reset_sync, adj_sync, sel_sync;
    logic pause_q, reset_q, t1_q, t2_q, armed;
    logic pause_rise, reset_rise, tick1, tick2, sw_adj, sw_sel;
    logic [3:0] min_t_n, min_o_n, sec_t_n, sec_o_n, blank_n;

    function automatic logic [7:0] bump_min(input logic [3:0] t, input logic [3:0] o);
        if (t == MAX_T && o == MAX_O) return 8'h00;
        if (o == 4'd9)                return {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] bump_sec(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd5 && o == 4'd9) return 8'h00;
        if (o == 4'd9)              return {t + 4'd1, 4'd0};
        return {t, o + 4'd1};
    endfunction

    assign sw_adj     = adj_sync[SYNC_STAGES-1];
    assign sw_sel     = sel_sync[SYNC_STAGES-1];
    assign pause_rise = pause_sync[SYNC_STAGES-1] & ~pause_q;
    assign reset_rise = reset_sync[SYNC_STAGES-1] & ~reset_q;
    // armed stays low for the first edge after reset so a level already high needs a fresh rise
    assign tick1      = TICK_1HZ & ~t1_q & armed;
    assign tick2      = TICK_2HZ & ~t2_q & armed;

    always_ff @(posedge CLK_REF or negedge RST_N) begin
        if (!RST_N) begin
            pause_sync <= '0;
            reset_sync <= '0;
            adj_sync   <= '0;
            sel_sync   <= '0;
            pause_q    <= 1'b0;
            reset_q    <= 1'b0;
            t1_q       <= 1'b0;
            t2_q       <= 1'b0;
            armed      <= 1'b0;
        end else begin
            pause_sync <= {pause_sync[SYNC_STAGES-2:0], BTN_PAUSE};
            reset_sync <= {reset_sync[SYNC_STAGES-2:0], BTN_RESET};
            adj_sync   <= {adj_sync[SYNC_STAGES-2:0], SW_ADJ};
            sel_sync   <= {sel_sync[SYNC_STAGES-2:0], SW_SEL};
            pause_q    <= pause_sync[SYNC_STAGES-1];
            reset_q    <= reset_sync[SYNC_STAGES-1];
            t1_q       <= TICK_1HZ;
            t2_q       <= TICK_2HZ;
            armed      <= 1'b1;
        end
    end

    always_ff @(posedge CLK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state     <= PAUSE;
            MIN_T     <= 4'd0;
            MIN_O     <= 4'd0;
            SEC_T     <= 4'd0;
            SEC_O     <= 4'd0;
            DIG_BLANK <= 4'b0000;
            RUNNING   <= 1'b0;
        end else begin
            state     <= state_next;
            MIN_T     <= min_t_n;
            MIN_O     <= min_o_n;
            SEC_T     <= sec_t_n;
            SEC_O     <= sec_o_n;
            DIG_BLANK <= blank_n;
            RUNNING   <= (state_next == RUN);
        end
    end

    // reset_rise outranks any transition, and a transition outranks an increment
    always_comb begin
        state_next = state;
        {min_t_n, min_o_n} = {MIN_T, MIN_O};
        {sec_t_n, sec_o_n} = {SEC_T, SEC_O};
        blank_n = 4'b0000;
        case (state)
            PAUSE: begin
                if (reset_rise)      state_next = PAUSE;
                else if (sw_adj)     state_next = ADJUST;
                else if (pause_rise) state_next = RUN;
            end
            RUN: begin
                if (reset_rise)  state_next = PAUSE;
                else if (sw_adj) state_next = ADJUST;
                else begin
                    if (pause_rise) state_next = PAUSE;
                    if (tick1) begin
                        {sec_t_n, sec_o_n} = bump_sec(SEC_T, SEC_O);
                        if (SEC_T == 4'd5 && SEC_O == 4'd9)
                            {min_t_n, min_o_n} = bump_min(MIN_T, MIN_O);
                    end
                end
            end
            ADJUST: begin
                if (reset_rise)   state_next = ADJUST;
                else if (!sw_adj) state_next = PAUSE;
                else if (tick2) begin
                    if (sw_sel) {sec_t_n, sec_o_n} = bump_sec(SEC_T, SEC_O);
                    else        {min_t_n, min_o_n} = bump_min(MIN_T, MIN_O);
                end
            end
            default: state_next = PAUSE;
        endcase
        if (reset_rise) begin
            {min_t_n, min_o_n, sec_t_n, sec_o_n} = 16'h0000;
        end
        if (state == ADJUST && !BLINK) begin
            blank_n = sw_sel ? 4'b0011 : 4'b1100;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl: run/pause, wrap, adjust, blanking,
// button priority and asynchronous reset behaviour.
module tb_stopwatch_ctrl;

    logic CLK_REF, RST_N, TICK_1HZ, TICK_2HZ, BLINK;
    logic BTN_PAUSE, BTN_RESET, SW_ADJ, SW_SEL;
    logic [3:0] MIN_T, MIN_O, SEC_T, SEC_O, DIG_BLANK;
    logic RUNNING;
    logic [15:0] time_bcd;
    int assert_count = 0;
    int fail_count = 0;

    assign time_bcd = {MIN_T, MIN_O, SEC_T, SEC_O};

    stopwatch_ctrl #(.MIN_MAX(59), .SYNC_STAGES(2)) dut (
        .CLK_REF(CLK_REF), .RST_N(RST_N), .TICK_1HZ(TICK_1HZ), .TICK_2HZ(TICK_2HZ),
        .BLINK(BLINK), .BTN_PAUSE(BTN_PAUSE), .BTN_RESET(BTN_RESET), .SW_ADJ(SW_ADJ),
        .SW_SEL(SW_SEL), .MIN_T(MIN_T), .MIN_O(MIN_O), .SEC_T(SEC_T), .SEC_O(SEC_O),
        .DIG_BLANK(DIG_BLANK), .RUNNING(RUNNING)
    );

    initial CLK_REF = 1'b0;
    always #5 CLK_REF = ~CLK_REF;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge CLK_REF);
        #1;
    endtask

    task automatic pulseTick1(input int n);
        for (int i = 0; i < n; i++) begin
            TICK_1HZ = 1'b1; applyStimulus(1);
            TICK_1HZ = 1'b0; applyStimulus(1);
        end
    endtask

    task automatic pulseTick2(input int n);
        for (int i = 0; i < n; i++) begin
            TICK_2HZ = 1'b1; applyStimulus(1);
            TICK_2HZ = 1'b0; applyStimulus(1);
        end
    endtask

    task automatic pressPause();
        BTN_PAUSE = 1'b1; applyStimulus(3);
        BTN_PAUSE = 1'b0; applyStimulus(3);
    endtask

    task automatic pressReset();
        BTN_RESET = 1'b1; applyStimulus(3);
        BTN_RESET = 1'b0; applyStimulus(3);
    endtask

    task automatic setSwitches(input logic adj, input logic sel);
        SW_ADJ = adj; SW_SEL = sel; applyStimulus(3);
    endtask

    initial begin
        RST_N = 1'b0; TICK_1HZ = 0; TICK_2HZ = 0; BLINK = 1'b1;
        BTN_PAUSE = 0; BTN_RESET = 0; SW_ADJ = 0; SW_SEL = 0;
        applyStimulus(3);
        checkOutput("reset_time", time_bcd, 16'h0000);
        checkOutput("reset_blank", {12'h0, DIG_BLANK}, 16'h0000);
        checkOutput("reset_running", {15'h0, RUNNING}, 16'h0000);
        RST_N = 1'b1;
        applyStimulus(2);

        // 1: run and count 61 seconds
        pressPause();
        checkOutput("t1_running", {15'h0, RUNNING}, 16'h0001);
        pulseTick1(61);
        checkOutput("t1_time", time_bcd, 16'h0101);
        checkOutput("t1_blank", {12'h0, DIG_BLANK}, 16'h0000);

        // 2: preload 59:59, wrap to 00:00
        setSwitches(1'b1, 1'b0);
        checkOutput("t2_adj_running", {15'h0, RUNNING}, 16'h0000);
        pulseTick2(58);
        setSwitches(1'b1, 1'b1);
        pulseTick2(58);
        checkOutput("t2_preload", time_bcd, 16'h5959);
        setSwitches(1'b0, 1'b1);
        checkOutput("t2_exit_running", {15'h0, RUNNING}, 16'h0000);
        pressPause();
        pulseTick1(1);
        checkOutput("t2_wrap", time_bcd, 16'h0000);
        pulseTick1(10);
        checkOutput("t2_ten", time_bcd, 16'h0010);

        // 3: pause holds time
        pressReset();
        checkOutput("t3_clear", time_bcd, 16'h0000);
        checkOutput("t3_clear_pause", {15'h0, RUNNING}, 16'h0000);
        pressPause();
        pulseTick1(5);
        checkOutput("t3_five", time_bcd, 16'h0005);
        pressPause();
        checkOutput("t3_paused", {15'h0, RUNNING}, 16'h0000);
        pulseTick1(5);
        checkOutput("t3_held", time_bcd, 16'h0005);
        pressPause();
        pulseTick1(1);
        checkOutput("t3_resume", time_bcd, 16'h0006);

        // 4: seconds adjust wrap and blanking
        setSwitches(1'b1, 1'b1);
        pulseTick2(52);
        checkOutput("t4_58", time_bcd, 16'h0058);
        pulseTick2(3);
        checkOutput("t4_wrap_nocarry", time_bcd, 16'h0001);
        pulseTick1(2);
        checkOutput("t4_tick1_ignored", time_bcd, 16'h0001);
        BLINK = 1'b0;
        #1;
        checkOutput("t4_blank_latency", {12'h0, DIG_BLANK}, 16'h0000);
        applyStimulus(1);
        checkOutput("t4_blank_sec", {12'h0, DIG_BLANK}, 16'h0003);
        setSwitches(1'b1, 1'b0);
        checkOutput("t4_blank_min", {12'h0, DIG_BLANK}, 16'h000C);
        BLINK = 1'b1;
        applyStimulus(1);
        checkOutput("t4_blank_off", {12'h0, DIG_BLANK}, 16'h0000);
        setSwitches(1'b0, 1'b0);
        checkOutput("t4_exit_running", {15'h0, RUNNING}, 16'h0000);
        pulseTick1(1);
        checkOutput("t4_pause_hold", time_bcd, 16'h0001);

        // 5: clear coincident with a tick, then a long hold
        setSwitches(1'b1, 1'b0);
        pulseTick2(12);
        setSwitches(1'b1, 1'b1);
        pulseTick2(33);
        checkOutput("t5_preload", time_bcd, 16'h1234);
        setSwitches(1'b0, 1'b1);
        pressPause();
        checkOutput("t5_run", {15'h0, RUNNING}, 16'h0001);
        BTN_RESET = 1'b1;
        applyStimulus(2);
        TICK_1HZ = 1'b1;
        applyStimulus(1);
        TICK_1HZ = 1'b0;
        checkOutput("t5_clear", time_bcd, 16'h0000);
        checkOutput("t5_clear_pause", {15'h0, RUNNING}, 16'h0000);
        pressPause();
        pulseTick1(3);
        applyStimulus(980);
        checkOutput("t5_held_once", time_bcd, 16'h0003);
        checkOutput("t5_held_run", {15'h0, RUNNING}, 16'h0001);
        BTN_RESET = 1'b0;
        applyStimulus(3);

        // 6: asynchronous reset with the 1 Hz level held high
        TICK_1HZ = 1'b1;
        applyStimulus(1);
        checkOutput("t6_pre", time_bcd, 16'h0004);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("t6_async_time", time_bcd, 16'h0000);
        checkOutput("t6_async_running", {15'h0, RUNNING}, 16'h0000);
        applyStimulus(2);
        RST_N = 1'b1;
        applyStimulus(3);
        pressPause();
        checkOutput("t6_run", {15'h0, RUNNING}, 16'h0001);
        checkOutput("t6_no_stale_tick", time_bcd, 16'h0000);
        TICK_1HZ = 1'b0;
        applyStimulus(1);
        TICK_1HZ = 1'b1;
        applyStimulus(1);
        TICK_1HZ = 1'b0;
        checkOutput("t6_fresh_tick", time_bcd, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM for the stopwatch. It consumes the square-wave outputs of the clock divider (1 Hz count tick, 2 Hz adjust tick, blink level), all generated in the CLK_REF domain, plus raw button and switch inputs. It sequences RUN, PAUSE and ADJUST modes and owns the MM:SS BCD time registers. It drives per-digit blank enables to the display multiplexer.

Parameters:
MIN_MAX, 59, highest minute value; MM:SS wraps to 00:00 after MIN_MAX:59
SYNC_STAGES, 2, synchroniser depth for BTN_* and SW_* inputs (allowed range 2..3)

Ports:
CLK_REF  in  1  system reference clock, rising-edge
RST_N  in  1  asynchronous active-low reset
TICK_1HZ  in  1  divider 1 Hz level, synchronous to CLK_REF
TICK_2HZ  in  1  divider 2 Hz level, synchronous to CLK_REF
BLINK  in  1  divider blink level, synchronous to CLK_REF
BTN_PAUSE  in  1  raw debounced pause/run button, asynchronous
BTN_RESET  in  1  raw debounced clear button, asynchronous
SW_ADJ  in  1  adjust-mode switch, asynchronous
SW_SEL  in  1  adjust field select (0 = minutes, 1 = seconds), asynchronous
MIN_T  out  4  minutes tens, BCD
MIN_O  out  4  minutes ones, BCD
SEC_T  out  4  seconds tens, BCD
SEC_O  out  4  seconds ones, BCD
DIG_BLANK  out  4  blank enables {MIN_T, MIN_O, SEC_T, SEC_O}; 1 = blank
RUNNING  out  1  high in RUN state

Behaviour:
- Reset: RST_N low asynchronously clears all registers. Outputs are 0, DIG_BLANK = 0000, RUNNING = 0, state = PAUSE, and all synchroniser and edge-history flops are 0.
- Inputs:
  - BTN_* and SW_* pass through SYNC_STAGES flops.
  - Buttons are rising-edge detected after synchronisation. With SYNC_STAGES = 2, the action registers on the 3rd CLK_REF edge after the input rises.
  - TICK_1HZ and TICK_2HZ are not synchronised. tick = level & ~level_q. The effect registers on the edge where tick is high.
- States:
  - PAUSE: time held. pause_rise -> RUN. sw_adj = 1 -> ADJUST.
  - RUN: on tick1, time advances by one second. pause_rise -> PAUSE. sw_adj = 1 -> ADJUST.
  - ADJUST: entered from RUN or PAUSE. sw_adj = 0 -> PAUSE, never directly to RUN. pause_rise is ignored.
- Time arithmetic (RUN, tick1):
  - SEC_O 9 -> 0 carries to SEC_T. SEC_T 5 with SEC_O 9 -> seconds become 00 and carry into minutes.
  - Minutes count to MIN_MAX in BCD. At MIN_MAX:59 the next tick gives 00:00.
  - Registers never hold non-BCD digits or seconds above 59.
- ADJUST: on tick2, the selected field (sw_sel) increments by one.
  - Seconds wrap 59 -> 00 with no carry into minutes.
  - Minutes wrap MIN_MAX -> 00.
  - The unselected field is held. tick1 is ignored.
- DIG_BLANK:
  - In ADJUST with BLINK = 0, the two digits of the selected field are blanked (sw_sel = 0 -> 1100, sw_sel = 1 -> 0011).
  - Otherwise DIG_BLANK = 0000. It is registered, so it follows BLINK with 1 cycle of latency.
- Priority within one cycle: reset_rise > state transition > increment.
  - reset_rise clears all digits to 0 in any state.
  - reset_rise in RUN forces PAUSE. In ADJUST the state is unchanged.
  - A tick in the same cycle as reset_rise is discarded.
  - pause_rise and tick1 in the same cycle in RUN: the tick is applied and the state goes to PAUSE.
  - A state change to ADJUST in the same cycle as tick1 discards the tick.
- Held buttons give one action per press. No auto-repeat.
- RUNNING = (state == RUN), registered.
- An RST_N assertion mid-count discards any pending edge history. After release, the first tick requires a fresh 0 -> 1 transition.

Test Plan:
1. Reset, then BTN_PAUSE pulse, then 61 TICK_1HZ rising edges -> RUNNING = 1, time 01:01, DIG_BLANK = 0000.
2. Preload 59:59 via ADJUST (MIN_MAX = 59), exit, run, 1 tick1 -> 00:00. A further 10 ticks -> 00:10.
3. In RUN at 00:05, BTN_PAUSE -> RUNNING = 0. 5 tick1 edges -> time stays 00:05. BTN_PAUSE again, 1 tick -> 00:06.
4. SW_ADJ = 1, SW_SEL = 1 at 00:58, 3 tick2 edges -> 00:01 (no minute carry). BLINK = 0 -> DIG_BLANK = 0011 one cycle later. SW_SEL = 0 with BLINK = 0 -> DIG_BLANK = 1100. SW_ADJ = 0 -> PAUSE, RUNNING = 0.
5. BTN_RESET asserted in the same cycle as a tick1 edge in RUN at 12:34 -> 00:00 and PAUSE, with no increment. Holding BTN_RESET for 1000 cycles produces only one action.
6. Drop RST_N asynchronously mid-count with TICK_1HZ high -> outputs 0 immediately. Release RST_N while TICK_1HZ is still high -> no increment until TICK_1HZ falls and rises again.
